vc_mem_bus: RTL and testbench

- Bus sequencer between the vc CPU core and the external 8-bit multiplexed memory bus.
- Converts one 16-bit-address byte or word read/write request per transaction into a strobe sequence on the pins: latch_hi, latch_lo, then data phases with byte select (ind) and write.
- Drives uo_out and uio_out[3:0] at top level.
- Also synchronises the external interrupt pin uio_in[7] for the core.

---
 rtl/vc_mem_bus.sv | 184 ++++++++++++++++++
 tb/tb_vc_mem_bus.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vc_mem_bus.sv
// Bus sequencer: turns one byte/word request into latch_hi/latch_lo/data strobes on the
// 8-bit multiplexed memory bus, plus a 2-flop irq synchroniser. Optional: VC_HI_CACHE_EN.
module vc_mem_bus #(
  parameter logic [7:0] IDLE_OUT = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_word,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rdone,
  output logic [15:0] rdata,
  output logic [7:0]  bus_out,
  input  logic [7:0]  bus_in,
  output logic        bus_ind,
  output logic        bus_write,
  output logic        bus_latch_hi,
  output logic        bus_latch_lo,
  input  logic        irq_pin,
  output logic        irq
);

  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    D0,
    D1
  } state_t;

  state_t      state_q;
  logic        ready_q;
  logic        rdone_q;
  logic [15:0] rdata_q;
  logic [7:0]  bus_out_q;
  logic        bus_ind_q;
  logic        bus_write_q;
  logic        latch_hi_q;
  logic        latch_lo_q;

  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        wr_q;
  logic        word_q;

  logic        irq_meta_q;
  logic        irq_q;

  logic        hi_hit;

`ifdef VC_HI_CACHE_EN
  logic [7:0]  hi_tag_q;
  logic        hi_valid_q;

  assign hi_hit = hi_valid_q && (hi_tag_q == req_addr[15:8]);

  // Tag is loaded on the accept that schedules HI, i.e. whenever HI executes.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_tag_q   <= '0;
      hi_valid_q <= 1'b0;
    end else if (state_q == IDLE && req_valid && !hi_hit) begin
      hi_tag_q   <= req_addr[15:8];
      hi_valid_q <= 1'b1;
    end
  end
`else
  assign hi_hit = 1'b0;
`endif

  // Outputs are loaded with the values of the state being entered, so every pin is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      rdone_q     <= 1'b0;
      rdata_q     <= '0;
      bus_out_q   <= IDLE_OUT;
      bus_ind_q   <= 1'b0;
      bus_write_q <= 1'b0;
      latch_hi_q  <= 1'b0;
      latch_lo_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      word_q      <= 1'b0;
    end else begin
      rdone_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid && ready_q) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wr_q    <= req_write;
            word_q  <= req_word;
            ready_q <= 1'b0;
            if (hi_hit) begin
              state_q    <= LO;
              bus_out_q  <= req_addr[7:0];
              latch_lo_q <= 1'b1;
            end else begin
              state_q    <= HI;
              bus_out_q  <= req_addr[15:8];
              latch_hi_q <= 1'b1;
            end
          end
        end
        HI: begin
          state_q    <= LO;
          bus_out_q  <= addr_q[7:0];
          latch_hi_q <= 1'b0;
          latch_lo_q <= 1'b1;
        end
        LO: begin
          state_q     <= D0;
          latch_lo_q  <= 1'b0;
          bus_ind_q   <= word_q ? 1'b0 : addr_q[0];
          bus_write_q <= wr_q;
          bus_out_q   <= wr_q ? wdata_q[7:0] : IDLE_OUT;
        end
        D0: begin
          if (!wr_q) begin
            rdata_q[7:0] <= bus_in;
            if (!word_q) begin
              rdata_q[15:8] <= '0;
            end
          end
          if (word_q) begin
            state_q     <= D1;
            bus_ind_q   <= 1'b1;
            bus_write_q <= wr_q;
            bus_out_q   <= wr_q ? wdata_q[15:8] : IDLE_OUT;
          end else begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            rdone_q     <= 1'b1;
            bus_out_q   <= IDLE_OUT;
            bus_ind_q   <= 1'b0;
            bus_write_q <= 1'b0;
          end
        end
        D1: begin
          if (!wr_q) begin
            rdata_q[15:8] <= bus_in;
          end
          state_q     <= IDLE;
          ready_q     <= 1'b1;
          rdone_q     <= 1'b1;
          bus_out_q   <= IDLE_OUT;
          bus_ind_q   <= 1'b0;
          bus_write_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_meta_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      irq_meta_q <= irq_pin;
      irq_q      <= irq_meta_q;
    end
  end

  assign req_ready    = ready_q;
  assign rdone        = rdone_q;
  assign rdata        = rdata_q;
  assign bus_out      = bus_out_q;
  assign bus_ind      = bus_ind_q;
  assign bus_write    = bus_write_q;
  assign bus_latch_hi = latch_hi_q;
  assign bus_latch_lo = latch_lo_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_vc_mem_bus.sv
// Self-checking bench for vc_mem_bus: external address latches and 64 KiB memory on the
// bus pins, a vector table of transactions, and hand sequences for reset and irq.
module tb_vc_mem_bus;

`ifdef VC_HI_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_word;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rdone;
  logic [15:0] rdata;
  logic [7:0]  bus_out;
  logic [7:0]  bus_in;
  logic        bus_ind;
  logic        bus_write;
  logic        bus_latch_hi;
  logic        bus_latch_lo;
  logic        irq_pin;
  logic        irq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vc_mem_bus #(.IDLE_OUT(8'h00)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_word(req_word),
    .req_addr(req_addr), .req_wdata(req_wdata), .rdone(rdone), .rdata(rdata),
    .bus_out(bus_out), .bus_in(bus_in), .bus_ind(bus_ind), .bus_write(bus_write),
    .bus_latch_hi(bus_latch_hi), .bus_latch_lo(bus_latch_lo),
    .irq_pin(irq_pin), .irq(irq)
  );

  // External memory system: latches and writes act on the falling edge.
  logic [7:0] mem [0:65535];
  logic [7:0] ext_hi = 8'h00;
  logic [6:0] ext_lo = 7'h00;

  assign bus_in = mem[{ext_hi, ext_lo, bus_ind}];

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h1234] = 8'hAB; mem[16'h1235] = 8'hCD;
    mem[16'h1250] = 8'h5A; mem[16'h1251] = 8'hA5;
    mem[16'h3000] = 8'h11; mem[16'h3001] = 8'h22;
    mem[16'h00FE] = 8'h0E; mem[16'h00FF] = 8'h0F; mem[16'h0100] = 8'h10;
    forever begin
      @(negedge clk);
      if (bus_write)    mem[{ext_hi, ext_lo, bus_ind}] = bus_out;
      if (bus_latch_hi) ext_hi = bus_out;
      if (bus_latch_lo) ext_lo = bus_out[7:1];
    end
  end

  typedef struct packed {
    logic        wr;
    logic        word;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic [3:0]  exp_lat;
    logic [1:0]  exp_wr;
    logic        hit;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Starts #1 after a rising edge; returns #1 after the edge on which rdone appeared.
  task automatic run_vec(input int i);
    vec_t       v;
    int         n;
    int         hi_cnt, lo_cnt, wr_cnt, d_cnt, overlap;
    logic [7:0] hi_val, lo_val;
    logic [1:0] d_ind;
    logic       lo_seen, exp_hi;
    v = vecs[i];
    exp_hi = !(CACHE && v.hit);
    chk($sformatf("v%0d_ready", i), {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = v.wr; req_word = v.word;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = ~v.addr; req_wdata = ~v.wdata; req_write = ~v.wr; req_word = ~v.word;
    n = 1; hi_cnt = 0; lo_cnt = 0; wr_cnt = 0; d_cnt = 0; overlap = 0;
    hi_val = 8'h00; lo_val = 8'h00; d_ind = 2'b00; lo_seen = 1'b0;
    while (!rdone && n < 12) begin
      if (int'(bus_latch_hi) + int'(bus_latch_lo) + int'(bus_write) > 1) overlap++;
      if (bus_latch_hi) begin hi_cnt++; hi_val = bus_out; end
      if (bus_latch_lo) begin
        lo_cnt++; lo_val = bus_out; lo_seen = 1'b1;
      end else if (lo_seen) begin
        if (d_cnt < 2) d_ind[d_cnt] = bus_ind;
        d_cnt++;
      end
      if (bus_write) wr_cnt++;
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("v%0d_latency", i), n, 32'(v.exp_lat) - 32'(!exp_hi));
    chk($sformatf("v%0d_rdata", i), {16'd0, rdata}, {16'd0, v.exp_rdata});
    chk($sformatf("v%0d_hi_cnt", i), hi_cnt, {31'd0, exp_hi});
    chk($sformatf("v%0d_hi_val", i), {24'd0, hi_val}, exp_hi ? {24'd0, v.addr[15:8]} : 32'd0);
    chk($sformatf("v%0d_lo_cnt", i), lo_cnt, 32'd1);
    chk($sformatf("v%0d_lo_val", i), {24'd0, lo_val}, {24'd0, v.addr[7:0]});
    chk($sformatf("v%0d_wr_cnt", i), wr_cnt, {30'd0, v.exp_wr});
    chk($sformatf("v%0d_data_cycles", i), d_cnt, v.word ? 32'd2 : 32'd1);
    chk($sformatf("v%0d_ind_seq", i), {30'd0, d_ind}, v.word ? 32'd2 : {31'd0, v.addr[0]});
    chk($sformatf("v%0d_overlap", i), overlap, 32'd0);
  endtask

  initial begin
    int rd_cnt;
    //            wr    word  addr      wdata     exp_rdata lat    nwr   hit
    vecs[0]  = '{1'b0, 1'b1, 16'h1234, 16'h0000, 16'hCDAB, 4'd5, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 16'h00FF, 16'h0055, 16'hCDAB, 4'd4, 2'd1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 16'h2000, 16'hBEEF, 16'hCDAB, 4'd5, 2'd2, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 16'h2000, 16'h0000, 16'hBEEF, 4'd5, 2'd0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 16'h1234, 16'h0000, 16'hCDAB, 4'd5, 2'd0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 16'h1235, 16'h0000, 16'h00CD, 4'd4, 2'd0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 16'h1235, 16'h0000, 16'hCDAB, 4'd5, 2'd0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 16'h1234, 16'h0000, 16'h00AB, 4'd4, 2'd0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 16'h1234, 16'h0000, 16'hCDAB, 4'd5, 2'd0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 16'h1250, 16'h0000, 16'hA55A, 4'd5, 2'd0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 16'h1250, 16'h0000, 16'hA55A, 4'd5, 2'd0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 16'h1251, 16'h0000, 16'h00A5, 4'd4, 2'd0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 16'h1250, 16'h0000, 16'hA55A, 4'd5, 2'd0, 1'b0};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_word = 1'b0;
    req_addr = '0; req_wdata = '0; irq_pin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rdone", {31'd0, rdone}, 32'd0);
    chk("rst_rdata", {16'd0, rdata}, 32'd0);
    chk("rst_bus_out", {24'd0, bus_out}, 32'd0);
    chk("rst_strobes", {28'd0, bus_ind, bus_write, bus_latch_hi, bus_latch_lo}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;

    irq_pin = 1'b1;
    @(posedge clk); #1; chk("irq_rise_1", {31'd0, irq}, 32'd0);
    @(posedge clk); #1; chk("irq_rise_2", {31'd0, irq}, 32'd1);
    irq_pin = 1'b0;
    @(posedge clk); #1; chk("irq_fall_1", {31'd0, irq}, 32'd1);
    @(posedge clk); #1; chk("irq_fall_2", {31'd0, irq}, 32'd0);

    for (int i = 0; i < 10; i++) run_vec(i);
    chk("mem_00FF", {24'd0, mem[16'h00FF]}, 32'h55);
    chk("mem_00FE", {24'd0, mem[16'h00FE]}, 32'h0E);
    chk("mem_0100", {24'd0, mem[16'h0100]}, 32'h10);
    chk("mem_2000", {24'd0, mem[16'h2000]}, 32'hEF);
    chk("mem_2001", {24'd0, mem[16'h2001]}, 32'hBE);

    // Reset during D0 of a word write to 0x3000.
    req_valid = 1'b1; req_write = 1'b1; req_word = 1'b1;
    req_addr = 16'h3000; req_wdata = 16'h7788;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_d0_write", {31'd0, bus_write}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_strobes", {28'd0, bus_ind, bus_write, bus_latch_hi, bus_latch_lo}, 32'd0);
    chk("mid_ready", {31'd0, req_ready}, 32'd1);
    rd_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (rdone) rd_cnt++;
      @(posedge clk); #1;
    end
    chk("mid_no_rdone", rd_cnt, 32'd0);
    chk("mid_mem_3000", {24'd0, mem[16'h3000]}, 32'h88);
    chk("mid_mem_3001", {24'd0, mem[16'h3001]}, 32'h22);

    run_vec(10);
    run_vec(11);
    do_reset();
    run_vec(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
